// File: rtl/ps2_kbd_frontend.sv
// PS/2 keyboard receive front end.
// Deserialises device-to-host frames and queues valid scan codes in a small
// ring FIFO. The head entry is shown as a raw byte, as lowercase ASCII, and
// as seven-segment patterns for both.
module ps2_kbd_frontend #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        nextdata_n,
   output logic [7:0]  data,
   output logic        ready,
   output logic        overflow,
   output logic [7:0]  ascii,
   output logic [15:0] seg_data,
   output logic [15:0] seg_ascii
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [2:0]       ps2_clk_sync_reg;
   logic [3:0]       bit_cnt_reg;
   logic [9:0]       shift_reg;      // [0]=start, [8:1]=d0..d7, [9]=parity
   logic [PTR_W-1:0] w_ptr_reg;
   logic [PTR_W-1:0] r_ptr_reg;
   logic             overflow_reg;
   logic [7:0]       fifo_mem [FIFO_DEPTH];

   logic             ps2_fall;
   logic             frame_ok;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             ovf_set;
   logic [PTR_W-1:0] w_ptr_next;
   logic [PTR_W-1:0] r_ptr_next;

   // Falling edge: the middle stage still high while the newest is low.
   assign ps2_fall = ps2_clk_sync_reg[1] & ~ps2_clk_sync_reg[0];

   // Eleventh edge closes the frame; ps2_data is the stop bit at this point.
   assign frame_ok = ps2_fall && (bit_cnt_reg == 4'd10) && !shift_reg[0]
                     && ps2_data && (^shift_reg[9:1]);

   assign w_ptr_next = (w_ptr_reg == PTR_LAST) ? '0 : w_ptr_reg + 1'b1;
   assign r_ptr_next = (r_ptr_reg == PTR_LAST) ? '0 : r_ptr_reg + 1'b1;
   assign fifo_empty = (w_ptr_reg == r_ptr_reg);
   assign fifo_full  = (w_ptr_next == r_ptr_reg);
   assign pop        = !fifo_empty && !nextdata_n;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push       = frame_ok && (!fifo_full || pop);
   assign ovf_set    = frame_ok && fifo_full && !pop;

   // Three-flop synchroniser on the PS/2 clock; idles high.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) ps2_clk_sync_reg <= 3'b111;
      else       ps2_clk_sync_reg <= {ps2_clk_sync_reg[1:0], ps2_clk};
   end

   // Bit counter and shift register: collect bits, restart after bit 11.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bit_cnt_reg <= 4'd0;
         shift_reg   <= 10'd0;
      end else if (ps2_fall) begin
         if (bit_cnt_reg == 4'd10) begin
            bit_cnt_reg <= 4'd0;
         end else begin
            shift_reg[bit_cnt_reg] <= ps2_data;
            bit_cnt_reg            <= bit_cnt_reg + 4'd1;
         end
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[w_ptr_reg] <= shift_reg[8:1];
   end

   // FIFO pointers and the sticky overflow flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         w_ptr_reg    <= '0;
         r_ptr_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)    w_ptr_reg    <= w_ptr_next;
         if (pop)     r_ptr_reg    <= r_ptr_next;
         if (ovf_set) overflow_reg <= 1'b1;
      end
   end

   assign ready    = !fifo_empty;
   assign overflow = overflow_reg;
   assign data     = fifo_empty ? 8'h00 : fifo_mem[r_ptr_reg];

   // Set-2 scan code to lowercase ASCII; unmapped codes give zero.
   always_comb begin
      ascii = 8'h00;
      case (data)
         8'h1C: ascii = "a";  8'h32: ascii = "b";  8'h21: ascii = "c";
         8'h23: ascii = "d";  8'h24: ascii = "e";  8'h2B: ascii = "f";
         8'h34: ascii = "g";  8'h33: ascii = "h";  8'h43: ascii = "i";
         8'h3B: ascii = "j";  8'h42: ascii = "k";  8'h4B: ascii = "l";
         8'h3A: ascii = "m";  8'h31: ascii = "n";  8'h44: ascii = "o";
         8'h4D: ascii = "p";  8'h15: ascii = "q";  8'h2D: ascii = "r";
         8'h1B: ascii = "s";  8'h2C: ascii = "t";  8'h3C: ascii = "u";
         8'h2A: ascii = "v";  8'h1D: ascii = "w";  8'h22: ascii = "x";
         8'h35: ascii = "y";  8'h1A: ascii = "z";
         8'h45: ascii = "0";  8'h16: ascii = "1";  8'h1E: ascii = "2";
         8'h26: ascii = "3";  8'h25: ascii = "4";  8'h2E: ascii = "5";
         8'h36: ascii = "6";  8'h3D: ascii = "7";  8'h3E: ascii = "8";
         8'h46: ascii = "9";
         8'h29: ascii = 8'h20;
         default: ascii = 8'h00;
      endcase
   end

   // Active-low a..g then dp (always off).
   function automatic logic [7:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;
         4'h3: seg7 = 8'h0D;  4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;
         4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;  4'h8: seg7 = 8'h01;
         4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
         4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;
         default: seg7 = 8'h71;
      endcase
   endfunction

   logic [31:0] nib_src;
   logic [31:0] seg_all;
   assign nib_src = {ascii, data};

   // One decoder per nibble: low two for data, high two for ascii.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_seg
         assign seg_all[gi*8 +: 8] = seg7(nib_src[gi*4 +: 4]);
      end
   endgenerate

   assign seg_data  = seg_all[15:0];
   assign seg_ascii = seg_all[31:16];

endmodule

// File: tb/tb_ps2_kbd_frontend.sv
// Directed bench for ps2_kbd_frontend: frames, pops, bad parity, overflow,
// pop on the accept cycle, and reset in the middle of a frame.
module tb_ps2_kbd_frontend;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        nextdata_n = 1'b1;
   logic [7:0]  data;
   logic        ready;
   logic        overflow;
   logic [7:0]  ascii;
   logic [15:0] seg_data;
   logic [15:0] seg_ascii;

   int total = 0;
   int bad = 0;

   ps2_kbd_frontend #(.FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .ascii      (ascii),
      .seg_data   (seg_data),
      .seg_ascii  (seg_ascii)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // One PS/2 bit: data set while ps2_clk high, then a falling edge.
   // With pop_at_edge set, nextdata_n is low for exactly the cycle in which
   // the DUT acts on this edge (second rising clk edge after the fall).
   task automatic send_bit(input logic b, input logic pop_at_edge);
      @(negedge clk) ps2_data = b;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_edge) begin
         @(negedge clk) nextdata_n = 1'b0;
         @(negedge clk) nextdata_n = 1'b1;
         repeat (3) @(negedge clk);
      end else begin
         repeat (5) @(negedge clk);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_on_stop);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(bits[i], (i == 10) && pop_on_stop);
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
   endtask

   task automatic pulse_reset();
      @(negedge clk) clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   logic [7:0] fill_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", {15'd0, ready}, 16'h0000);
      check("rst_data", {8'd0, data}, 16'h0000);
      check("rst_ascii", {8'd0, ascii}, 16'h0000);
      check("rst_seg_data", seg_data, 16'h0303);
      check("rst_seg_ascii", seg_ascii, 16'h0303);
      check("rst_overflow", {15'd0, overflow}, 16'h0000);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame 0x1C -> 'a'
      send_frame(8'h1C, 1'b0, 1'b0);
      check("a_ready", {15'd0, ready}, 16'h0001);
      check("a_data", {8'd0, data}, 16'h001C);
      check("a_ascii", {8'd0, ascii}, 16'h0061);
      check("a_seg_data", seg_data, 16'h9F63);
      check("a_seg_ascii", seg_ascii, 16'h419F);
      check("a_overflow", {15'd0, overflow}, 16'h0000);
      pop_one();
      check("a_pop_ready", {15'd0, ready}, 16'h0000);

      // Ordering with a break prefix
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("seq_data0", {8'd0, data}, 16'h001C);
      pop_one();
      check("seq_data1", {8'd0, data}, 16'h00F0);
      check("seq_ascii1", {8'd0, ascii}, 16'h0000);
      check("seq_seg1", seg_data, 16'h7103);
      pop_one();
      check("seq_data2", {8'd0, data}, 16'h001C);
      pop_one();
      check("seq_end_ready", {15'd0, ready}, 16'h0000);
      check("seq_end_data", {8'd0, data}, 16'h0000);
      pop_one();
      check("pop_empty_ready", {15'd0, ready}, 16'h0000);

      // Bad parity dropped, good frame accepted
      send_frame(8'h45, 1'b1, 1'b0);
      check("badpar_ready", {15'd0, ready}, 16'h0000);
      send_frame(8'h45, 1'b0, 1'b0);
      check("goodpar_data", {8'd0, data}, 16'h0045);
      check("goodpar_ascii", {8'd0, ascii}, 16'h0030);
      pop_one();

      // Fill to 7, then an 8th overflows
      for (int i = 0; i < 7; i++) send_frame(fill_codes[i], 1'b0, 1'b0);
      check("fill7_ready", {15'd0, ready}, 16'h0001);
      check("fill7_overflow", {15'd0, overflow}, 16'h0000);
      send_frame(fill_codes[7], 1'b0, 1'b0);
      check("fill8_overflow", {15'd0, overflow}, 16'h0001);
      for (int i = 0; i < 7; i++) begin
         check($sformatf("ovf_pop%0d", i), {8'd0, data}, {8'd0, fill_codes[i]});
         pop_one();
      end
      check("ovf_drain_ready", {15'd0, ready}, 16'h0000);
      check("ovf_sticky", {15'd0, overflow}, 16'h0001);
      pulse_reset();
      check("ovf_cleared", {15'd0, overflow}, 16'h0000);

      // Pop on the accept cycle while full: no overflow, still 7 held
      for (int i = 0; i < 7; i++) send_frame(fill_codes[i], 1'b0, 1'b0);
      send_frame(fill_codes[7], 1'b0, 1'b1);
      check("popacc_overflow", {15'd0, overflow}, 16'h0000);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("popacc_pop%0d", i), {8'd0, data}, {8'd0, fill_codes[i]});
         pop_one();
      end
      check("popacc_drain_ready", {15'd0, ready}, 16'h0000);

      // Reset after start + 5 data bits, then a full 0x29 frame
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
      pulse_reset();
      send_frame(8'h29, 1'b0, 1'b0);
      check("midrst_data", {8'd0, data}, 16'h0029);
      check("midrst_ascii", {8'd0, ascii}, 16'h0020);
      check("midrst_seg_ascii", seg_ascii, 16'h2503);
      pop_one();
      check("midrst_one_entry", {15'd0, ready}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
